pe_bottom_edge_acc: RTL and testbench

- Parametrised bottom-row processing element for the systolic matrix-multiply array.
- Accumulates signed a*b products over a valid-qualified dot-product stream.
- Forwards a/b operands to neighbours with one-cycle registered latency.
- On an end-of-vector marker, requantises the accumulator to OWIDTH and presents it on a valid/ready result port toward the output buffer.

---
 rtl/pe_bottom_edge_acc.sv | 170 +++++++++++++++++
 tb/tb_pe_bottom_edge_acc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_bottom_edge_acc.sv
// Bottom-row systolic PE: forwards operands, accumulates signed a*b dot products,
// requantises on in_last onto a valid/ready result port. Macro PE_SATURATE_EN selects clamping.
module pe_bottom_edge_acc #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 32,
    parameter int OWIDTH = 8,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    input  logic              in_last,
    output logic [DWIDTH-1:0] out_a,
    output logic [DWIDTH-1:0] out_b,
    output logic              out_valid,
    output logic              out_last,
    output logic [OWIDTH-1:0] out_c,
    output logic              c_valid,
    input  logic              c_ready,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic signed [AWIDTH-1:0]   acc_q, acc_d;
    logic [DWIDTH-1:0]          out_a_q, out_a_d;
    logic [DWIDTH-1:0]          out_b_q, out_b_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic [OWIDTH-1:0]          out_c_q, out_c_d;
    logic                       c_valid_q, c_valid_d;
    logic                       overrun_q, overrun_d;

    logic signed [2*DWIDTH-1:0] a_ext_s, b_ext_s, prod_s;
    logic signed [AWIDTH-1:0]   p_ext_s, sum_s, shifted_s;
    logic                       result_fire_s, xfer_s;

`ifdef PE_SATURATE_EN
    localparam logic signed [AWIDTH-1:0] OMAX = {{(AWIDTH-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] OMIN = {{(AWIDTH-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};
`endif

    function automatic logic [OWIDTH-1:0] narrow(input logic signed [AWIDTH-1:0] s);
        logic [OWIDTH-1:0] r;
`ifdef PE_SATURATE_EN
        if (s > OMAX) begin
            r = OMAX[OWIDTH-1:0];
        end else if (s < OMIN) begin
            r = OMIN[OWIDTH-1:0];
        end else begin
            r = s[OWIDTH-1:0];
        end
`else
        r = s[OWIDTH-1:0];
`endif
        return r;
    endfunction

    // Signed product, widened to the accumulator, and the requantised running sum
    always_comb begin
        a_ext_s   = (2*DWIDTH)'($signed(in_a));
        b_ext_s   = (2*DWIDTH)'($signed(in_b));
        prod_s    = a_ext_s * b_ext_s;
        p_ext_s   = AWIDTH'(prod_s);
        if (state_q == ST_ACC) begin
            sum_s = acc_q + p_ext_s;
        end else begin
            sum_s = p_ext_s;
        end
        shifted_s = sum_s >>> SHIFT;
    end

    // Next-state logic: accumulator FSM, pass-through and result handshake
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        out_a_d       = in_a;
        out_b_d       = in_b;
        out_valid_d   = in_valid;
        out_last_d    = in_valid & in_last;
        out_c_d       = out_c_q;
        c_valid_d     = c_valid_q;
        overrun_d     = overrun_q;
        result_fire_s = in_valid & in_last;
        xfer_s        = c_valid_q & c_ready;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && !in_last) begin
                    acc_d   = p_ext_s;
                    state_d = ST_ACC;
                end else begin
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (in_valid && in_last) begin
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    acc_d   = sum_s;
                end else begin
                    acc_d   = acc_q;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A new result always wins; it only counts as lost if the old one was still stalled
        if (result_fire_s) begin
            out_c_d   = narrow(shifted_s);
            c_valid_d = 1'b1;
            if (c_valid_q && !c_ready) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (xfer_s) begin
            c_valid_d = 1'b0;
        end else begin
            c_valid_d = c_valid_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_c_q     <= '0;
            c_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_c_q     <= out_c_d;
            c_valid_q   <= c_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_c     = out_c_q;
    assign c_valid   = c_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == ST_ACC);

endmodule

// File: tb/tb_pe_bottom_edge_acc.sv
// Self-checking bench for pe_bottom_edge_acc: SHIFT=0 and SHIFT=4 instances share stimulus
// and are compared every cycle against a dot-product model, plus pinned literal checks.
module tb_pe_bottom_edge_acc;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       c_ready;

    logic [7:0] out_a0, out_b0, out_c0;
    logic       out_valid0, out_last0, c_valid0, busy0, overrun0;
    logic [7:0] out_a4, out_b4, out_c4;
    logic       out_valid4, out_last4, c_valid4, busy4, overrun4;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    // Model state: mathematical running sum of the current vector and the expected outputs
    longint     vec_sum = 0;
    logic       in_vec = 1'b0;
    logic [7:0] exp_a = 8'd0, exp_b = 8'd0, exp_c0 = 8'd0, exp_c4 = 8'd0;
    logic       exp_v = 1'b0, exp_l = 1'b0, exp_cv = 1'b0, exp_ovr = 1'b0;

    pe_bottom_edge_acc #(.DWIDTH(8), .AWIDTH(32), .OWIDTH(8), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_a(out_a0), .out_b(out_b0), .out_valid(out_valid0),
        .out_last(out_last0), .out_c(out_c0), .c_valid(c_valid0), .c_ready(c_ready),
        .busy(busy0), .overrun(overrun0)
    );

    pe_bottom_edge_acc #(.DWIDTH(8), .AWIDTH(32), .OWIDTH(8), .SHIFT(4)) dut_sh4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_a(out_a4), .out_b(out_b4), .out_valid(out_valid4),
        .out_last(out_last4), .out_c(out_c4), .c_valid(c_valid4), .c_ready(c_ready),
        .busy(busy4), .overrun(overrun4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint prod_of(input logic [7:0] a, input logic [7:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic [7:0] requant(input longint total, input int sh);
        longint w;
        longint s;
        logic [63:0] bits;
        w = longint'(int'(total));
        s = w >>> sh;
`ifdef PE_SATURATE_EN
        if (s > 127) return 8'h7f;
        if (s < -128) return 8'h80;
`endif
        bits = s;
        return bits[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advanced on each active edge from the inputs seen on that edge
    always @(posedge clk) begin
        if (reset) begin
            vec_sum <= 0; in_vec <= 1'b0;
            exp_a <= 8'd0; exp_b <= 8'd0; exp_v <= 1'b0; exp_l <= 1'b0;
            exp_c0 <= 8'd0; exp_c4 <= 8'd0; exp_cv <= 1'b0; exp_ovr <= 1'b0;
        end else begin
            exp_a <= in_a; exp_b <= in_b; exp_v <= in_valid; exp_l <= in_valid & in_last;
            if (in_valid && in_last) begin
                exp_c0  <= requant(vec_sum + prod_of(in_a, in_b), 0);
                exp_c4  <= requant(vec_sum + prod_of(in_a, in_b), 4);
                exp_cv  <= 1'b1;
                if (exp_cv && !c_ready) exp_ovr <= 1'b1;
                vec_sum <= 0;
                in_vec  <= 1'b0;
            end else begin
                if (in_valid) begin
                    vec_sum <= vec_sum + prod_of(in_a, in_b);
                    in_vec  <= 1'b1;
                end
                if (exp_cv && c_ready) exp_cv <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("out_a",     {24'd0, out_a0},     {24'd0, exp_a});
                check("out_b",     {24'd0, out_b0},     {24'd0, exp_b});
                check("out_valid", {31'd0, out_valid0}, {31'd0, exp_v});
                check("out_last",  {31'd0, out_last0},  {31'd0, exp_l});
                check("out_c",     {24'd0, out_c0},     {24'd0, exp_c0});
                check("c_valid",   {31'd0, c_valid0},   {31'd0, exp_cv});
                check("busy",      {31'd0, busy0},      {31'd0, in_vec});
                check("overrun",   {31'd0, overrun0},   {31'd0, exp_ovr});
                check("sh4_out_a", {24'd0, out_a4},     {24'd0, exp_a});
                check("sh4_out_c", {24'd0, out_c4},     {24'd0, exp_c4});
                check("sh4_cvalid",{31'd0, c_valid4},   {31'd0, exp_cv});
                check("sh4_busy",  {31'd0, busy4},      {31'd0, in_vec});
                check("sh4_ovr",   {31'd0, overrun4},   {31'd0, exp_ovr});
                check("sh4_last",  {31'd0, out_last4},  {31'd0, exp_l});
                check("sh4_valid", {31'd0, out_valid4}, {31'd0, exp_v});
                check("sh4_out_b", {24'd0, out_b4},     {24'd0, exp_b});
            end
        end
    end

    task automatic step(input logic v, input int a, input int b, input logic l);
        in_valid = v;
        in_a     = a[7:0];
        in_b     = b[7:0];
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0; c_ready = 1'b1;
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 9, 9, 1'b0);
        check("rst_out_c",   {24'd0, out_c0},    32'd0);
        check("rst_c_valid", {31'd0, c_valid0},  32'd0);
        check("rst_busy",    {31'd0, busy0},     32'd0);
        check("rst_out_val", {31'd0, out_valid0}, 32'd0);
        reset = 1'b0;

        // Basic dot product 3*4 - 2*5 + 7*7 = 51
        step(1'b1, 3, 4, 1'b0);
        check("basic_busy1", {31'd0, busy0}, 32'd1);
        step(1'b1, -2, 5, 1'b0);
        check("basic_busy2", {31'd0, busy0}, 32'd1);
        step(1'b1, 7, 7, 1'b1);
        check("basic_out_c", {24'd0, out_c0}, 32'd51);
        check("basic_cval",  {31'd0, c_valid0}, 32'd1);
        check("basic_busy3", {31'd0, busy0}, 32'd0);
        step(1'b0, 0, 0, 1'b0);
        check("basic_xfer",  {31'd0, c_valid0}, 32'd0);

        // Large sums: 32258 and -32512
        step(1'b1, 127, 127, 1'b0);
        step(1'b1, 127, 127, 1'b1);
`ifdef PE_SATURATE_EN
        check("sat_pos", {24'd0, out_c0}, 32'h7f);
`else
        check("trunc_pos", {24'd0, out_c0}, 32'h02);
`endif
        step(1'b1, -128, 127, 1'b0);
        step(1'b1, -128, 127, 1'b1);
`ifdef PE_SATURATE_EN
        check("sat_neg", {24'd0, out_c0}, 32'h80);
`else
        check("trunc_neg", {24'd0, out_c0}, 32'h00);
`endif
        step(1'b0, 0, 0, 1'b0);

        // Single beat 100 >>> 4 = 6
        step(1'b1, 10, 10, 1'b1);
        check("shift_out_c", {24'd0, out_c4}, 32'd6);
        check("shift_busy",  {31'd0, busy4},  32'd0);
        step(1'b0, 0, 0, 1'b0);

        // Backpressure and overrun
        c_ready = 1'b0;
        step(1'b1, 2, 3, 1'b1);
        check("bp_first", {24'd0, out_c0}, 32'd6);
        check("bp_novr",  {31'd0, overrun0}, 32'd0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b1, 4, 5, 1'b1);
        check("bp_second", {24'd0, out_c0}, 32'd20);
        check("bp_ovr",    {31'd0, overrun0}, 32'd1);
        step(1'b0, 0, 0, 1'b0);
        check("bp_hold",   {31'd0, c_valid0}, 32'd1);
        c_ready = 1'b1;
        step(1'b0, 0, 0, 1'b0);
        check("bp_xfer",   {31'd0, c_valid0}, 32'd0);
        check("bp_sticky", {31'd0, overrun0}, 32'd1);

        // Transfer and new result on the same edge
        reset = 1'b1;
        step(1'b0, 0, 0, 1'b0);
        reset = 1'b0;
        c_ready = 1'b0;
        step(1'b1, 2, 3, 1'b1);
        c_ready = 1'b1;
        step(1'b1, 1, 9, 1'b1);
        check("simul_out_c", {24'd0, out_c0}, 32'd9);
        check("simul_cval",  {31'd0, c_valid0}, 32'd1);
        check("simul_novr",  {31'd0, overrun0}, 32'd0);
        step(1'b0, 0, 0, 1'b0);

        // Reset in the middle of a vector
        step(1'b1, 5, 6, 1'b0);
        step(1'b1, 7, 8, 1'b0);
        check("mid_busy", {31'd0, busy0}, 32'd1);
        reset = 1'b1;
        step(1'b1, 9, 9, 1'b0);
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        check("mid_rst_a",    {24'd0, out_a0}, 32'd0);
        check("mid_rst_cv",   {31'd0, c_valid0}, 32'd0);
        step(1'b1, 1, 1, 1'b1);
        check("mid_out_c", {24'd0, out_c0}, 32'd1);
        check("mid_cval",  {31'd0, c_valid0}, 32'd1);

        // Mixed traffic with gaps, stray in_last and random backpressure
        for (int i = 0; i < 60; i++) begin
            c_ready = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
        end
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
